// File: rtl/oit_counter_pkg.sv
// ==== oit_counter_pkg: shared modes, direction type and parameter checks ====
// ==== rev 1.0 ====
`default_nettype none

package oit_counter_pkg;

   localparam int OIT_CNT_WRAP = 0;
   localparam int OIT_CNT_SAT  = 1;

   typedef enum logic {
      OIT_DIR_DOWN = 1'b0,
      OIT_DIR_UP   = 1'b1
   } oit_dir_e;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int oitBits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic bit oitCountOk(input int count);
      return count >= 2;
   endfunction

   function automatic bit oitStepOk(input int step, input int count);
      return (step >= 1) && (step <= count - 1);
   endfunction

   function automatic bit oitModeOk(input int mode);
      return (mode == OIT_CNT_WRAP) || (mode == OIT_CNT_SAT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/oit_mod_counter_next.sv
// ==== oit_mod_counter_next: next count, terminal count and wrap flag ====
// ==== rev 1.0 ====
`default_nettype none

module oit_mod_counter_next
   import oit_counter_pkg::*;
#(
   parameter int COUNT    = 10,
   parameter int STEP     = 1,
   parameter int SATURATE = OIT_CNT_WRAP,
   parameter int WIDTH    = oitBits(COUNT)
) (
   input  logic [WIDTH-1:0] out_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] next_o,
   output logic             tc_o,
   output logic             wrap_o
);

   localparam logic [WIDTH:0]   C_COUNT = (WIDTH+1)'(COUNT);
   localparam logic [WIDTH:0]   C_STEP  = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] C_MAX   = WIDTH'(COUNT - 1);
   localparam bit               C_SAT   = (SATURATE == OIT_CNT_SAT);

   oit_dir_e       w_dir;
   logic [WIDTH:0] w_out_ext;
   logic [WIDTH:0] w_sum;
   logic           w_up_over;
   logic           w_dn_under;
   logic [WIDTH-1:0] w_up_plain;
   logic [WIDTH-1:0] w_up_wrap;
   logic [WIDTH-1:0] w_dn_plain;
   logic [WIDTH-1:0] w_dn_wrap;

   assign w_dir      = oit_dir_e'(up_i);
   assign w_out_ext  = {1'b0, out_i};
   // One spare bit so out+STEP cannot silently overflow before the compare.
   assign w_sum      = w_out_ext + C_STEP;
   assign w_up_over  = (w_sum >= C_COUNT);
   assign w_dn_under = (w_out_ext < C_STEP);
   assign w_up_plain = WIDTH'(w_sum);
   assign w_up_wrap  = WIDTH'(w_sum - C_COUNT);
   assign w_dn_plain = WIDTH'(w_out_ext - C_STEP);
   assign w_dn_wrap  = WIDTH'(w_out_ext + (C_COUNT - C_STEP));

   assign tc_o = (w_dir == OIT_DIR_UP) ? w_up_over : w_dn_under;

   always_comb begin
      next_o = out_i;
      wrap_o = 1'b0;
      if (w_dir == OIT_DIR_UP) begin
         if (!w_up_over) begin
            next_o = w_up_plain;
         end else if (C_SAT) begin
            next_o = C_MAX;
         end else begin
            next_o = w_up_wrap;
            wrap_o = 1'b1;
         end
      end else begin
         if (!w_dn_under) begin
            next_o = w_dn_plain;
         end else if (C_SAT) begin
            next_o = '0;
         end else begin
            next_o = w_dn_wrap;
            wrap_o = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/oit_mod_counter.sv
// ==== oit_mod_counter: modulo-COUNT up/down counter, load, wrap/saturate ====
// ==== rev 1.0 ====
`default_nettype none

module oit_mod_counter
   import oit_counter_pkg::*;
#(
   parameter int COUNT    = 10,
   parameter int STEP     = 1,
   parameter int SATURATE = OIT_CNT_WRAP,
   parameter int WIDTH    = oitBits(COUNT)
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             up_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   output logic [WIDTH-1:0] out_o,
   output logic             tc_o,
   output logic             carry_out_o,
   output logic             wrapped_o,
   output logic             load_err_o
);

   generate
      if (!oitCountOk(COUNT)) begin : g_bad_count
         $error("oit_mod_counter: COUNT must be >= 2");
      end
      if (!oitStepOk(STEP, COUNT)) begin : g_bad_step
         $error("oit_mod_counter: STEP must be in 1..COUNT-1");
      end
      if (!oitModeOk(SATURATE)) begin : g_bad_mode
         $error("oit_mod_counter: SATURATE must be 0 or 1");
      end
   endgenerate

   localparam logic [WIDTH:0]   C_COUNT = (WIDTH+1)'(COUNT);
   localparam logic [WIDTH-1:0] C_MAX   = WIDTH'(COUNT - 1);

   logic [WIDTH-1:0] out_q, out_d;
   logic             wrapped_q, wrapped_d;
   logic             load_err_q, load_err_d;
   logic [WIDTH-1:0] w_next;
   logic             w_tc;
   logic             w_wrap;
   logic             w_load_oor;

   oit_mod_counter_next #(
      .COUNT    (COUNT),
      .STEP     (STEP),
      .SATURATE (SATURATE),
      .WIDTH    (WIDTH)
   ) u_next (
      .out_i  (out_q),
      .up_i   (up_i),
      .next_o (w_next),
      .tc_o   (w_tc),
      .wrap_o (w_wrap)
   );

   assign w_load_oor = ({1'b0, load_value_i} >= C_COUNT);

   // Priority below reset: load, then count, then hold.
   always_comb begin
      out_d      = out_q;
      wrapped_d  = 1'b0;
      load_err_d = 1'b0;
      if (load_i) begin
         if (w_load_oor) begin
            out_d      = C_MAX;
            load_err_d = 1'b1;
         end else begin
            out_d = load_value_i;
         end
      end else if (enable_i) begin
         out_d     = w_next;
         wrapped_d = w_wrap;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         out_q      <= '0;
         wrapped_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         wrapped_q  <= wrapped_d;
         load_err_q <= load_err_d;
      end
   end

   assign out_o       = out_q;
   assign tc_o        = w_tc;
   assign carry_out_o = enable_i & w_tc & ~load_i & ~reset_i;
   assign wrapped_o   = wrapped_q;
   assign load_err_o  = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_oit_mod_counter.sv
// ==== tb_oit_mod_counter: wrap/saturate counters against a reference model ====
// ==== rev 1.0 ====
`default_nettype none

module tb_oit_mod_counter;

   localparam int M_COUNT = 10;
   localparam int M_STEP  = 3;
   localparam int W       = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Shared stimulus for the wrap (index 0) and saturate (index 1) counters.
   logic         s_rst, s_en, s_up, s_ld;
   logic [W-1:0] s_lv;
   logic [W-1:0] d_out [2];
   logic         d_tc  [2];
   logic         d_co  [2];
   logic         d_wr  [2];
   logic         d_le  [2];

   oit_mod_counter #(.COUNT(M_COUNT), .STEP(M_STEP), .SATURATE(0)) u_wrap (
      .clock_i(clk), .reset_i(s_rst), .enable_i(s_en), .up_i(s_up),
      .load_i(s_ld), .load_value_i(s_lv), .out_o(d_out[0]), .tc_o(d_tc[0]),
      .carry_out_o(d_co[0]), .wrapped_o(d_wr[0]), .load_err_o(d_le[0]));

   oit_mod_counter #(.COUNT(M_COUNT), .STEP(M_STEP), .SATURATE(1)) u_sat (
      .clock_i(clk), .reset_i(s_rst), .enable_i(s_en), .up_i(s_up),
      .load_i(s_ld), .load_value_i(s_lv), .out_o(d_out[1]), .tc_o(d_tc[1]),
      .carry_out_o(d_co[1]), .wrapped_o(d_wr[1]), .load_err_o(d_le[1]));

   // Two-digit decimal cascade.
   logic         c_rst, c_en;
   logic [W-1:0] c_zero = '0;
   logic [W-1:0] lo_out, hi_out;
   logic         lo_tc, lo_co, lo_wr, lo_le, hi_tc, hi_co, hi_wr, hi_le;

   oit_mod_counter #(.COUNT(10), .STEP(1), .SATURATE(0)) u_lo (
      .clock_i(clk), .reset_i(c_rst), .enable_i(c_en), .up_i(1'b1),
      .load_i(1'b0), .load_value_i(c_zero), .out_o(lo_out), .tc_o(lo_tc),
      .carry_out_o(lo_co), .wrapped_o(lo_wr), .load_err_o(lo_le));

   oit_mod_counter #(.COUNT(10), .STEP(1), .SATURATE(0)) u_hi (
      .clock_i(clk), .reset_i(c_rst), .enable_i(lo_co), .up_i(1'b1),
      .load_i(1'b0), .load_value_i(c_zero), .out_o(hi_out), .tc_o(hi_tc),
      .carry_out_o(hi_co), .wrapped_o(hi_wr), .load_err_o(hi_le));

   // Reference model state.
   int m_out [2];
   bit m_wr  [2];
   bit m_le  [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_next(input int o, input bit up, input bit sat, output bit wr);
      wr = 1'b0;
      if (up) begin
         if (o + M_STEP < M_COUNT) return o + M_STEP;
         if (sat) return M_COUNT - 1;
         wr = 1'b1;
         return (o + M_STEP) % M_COUNT;
      end
      if (o - M_STEP >= 0) return o - M_STEP;
      if (sat) return 0;
      wr = 1'b1;
      return (o - M_STEP + M_COUNT) % M_COUNT;
   endfunction

   task automatic cyc(input bit rst, input bit en, input bit up, input bit ld, input int lv);
      bit exp_tc;
      bit wr;
      s_rst = rst; s_en = en; s_up = up; s_ld = ld; s_lv = W'(lv);
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_tc = up ? (m_out[k] + M_STEP >= M_COUNT) : (m_out[k] < M_STEP);
         chk($sformatf("tc[%0d]", k), 32'(d_tc[k]), 32'(exp_tc));
         chk($sformatf("carry[%0d]", k), 32'(d_co[k]), 32'(en & exp_tc & ~ld & ~rst));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_out[k] = 0; m_wr[k] = 0; m_le[k] = 0;
         end else if (ld) begin
            m_wr[k]  = 0;
            m_le[k]  = (lv >= M_COUNT);
            m_out[k] = (lv >= M_COUNT) ? M_COUNT - 1 : lv;
         end else if (en) begin
            m_out[k] = ref_next(m_out[k], up, k == 1, wr);
            m_wr[k]  = wr; m_le[k] = 0;
         end else begin
            m_wr[k] = 0; m_le[k] = 0;
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("out[%0d]", k), 32'(d_out[k]), 32'(m_out[k]));
         chk($sformatf("wrapped[%0d]", k), 32'(d_wr[k]), 32'(m_wr[k]));
         chk($sformatf("load_err[%0d]", k), 32'(d_le[k]), 32'(m_le[k]));
      end
   endtask

   initial begin
      int hi_wraps;
      s_rst = 1'b1; s_en = 1'b0; s_up = 1'b1; s_ld = 1'b0; s_lv = '0;
      c_rst = 1'b1; c_en = 1'b0;
      for (int k = 0; k < 2; k++) begin m_out[k] = 0; m_wr[k] = 0; m_le[k] = 0; end
      @(posedge clk); #1;

      cyc(1, 0, 1, 0, 0);                         // reset state
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);  // 0,3,6,9,2
      cyc(0, 1, 0, 0, 0);                         // 2 -> 9 wraps
      cyc(0, 1, 0, 0, 0);                         // 9 -> 6
      cyc(0, 0, 1, 1, 8);                         // load 8
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);  // saturate at 9
      cyc(0, 0, 0, 1, 1);
      for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, 0);  // saturate at 0
      cyc(0, 0, 1, 1, 12);                        // out-of-range load
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 4);
      cyc(1, 1, 1, 1, 7);                         // reset beats everything
      cyc(0, 1, 1, 1, 5);                         // load beats enable
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);  // hold

      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
      end

      // Cascade: 100 low-stage enables walk 00..99 and roll back to 00.
      @(posedge clk); #1;
      c_rst = 1'b0;
      chk("cascade_reset", 32'(hi_out) * 10 + 32'(lo_out), 32'd0);
      c_en = 1'b1;
      hi_wraps = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (hi_wr) hi_wraps++;
         chk("cascade_val", 32'(hi_out) * 10 + 32'(lo_out), 32'(i % 100));
      end
      c_en = 1'b0;
      chk("cascade_hi_wraps", 32'(hi_wraps), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
